// File: rtl/demux1to4_reg.sv
// rtl/demux1to4_reg.sv - registered 1-to-4 demultiplexer with per-lane holding register and counter
module demux1to4_reg #(
  parameter int NUM_BITS = 512,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] out0_data,
  output logic                out0_valid,
  input  logic                out0_ready,
  output logic [CNT_W-1:0]    out0_cnt,
  output logic [NUM_BITS-1:0] out1_data,
  output logic                out1_valid,
  input  logic                out1_ready,
  output logic [CNT_W-1:0]    out1_cnt,
  output logic [NUM_BITS-1:0] out2_data,
  output logic                out2_valid,
  input  logic                out2_ready,
  output logic [CNT_W-1:0]    out2_cnt,
  output logic [NUM_BITS-1:0] out3_data,
  output logic                out3_valid,
  input  logic                out3_ready,
  output logic [CNT_W-1:0]    out3_cnt
);

  logic [NUM_BITS-1:0] data_q [4];
  logic [CNT_W-1:0]    cnt_q  [4];
  logic [3:0]          valid_q;
  logic [3:0]          ready_v;
  logic                accept;

  assign ready_v = {out3_ready, out2_ready, out1_ready, out0_ready};

  // Only the selected lane gates acceptance; a lane being drained this edge frees its slot.
  assign in_ready = rst_n & (~valid_q[in_sel] | ready_v[in_sel]);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k]  <= '0;
        cnt_q[k]   <= '0;
        valid_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (in_sel == 2'(k))) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
          cnt_q[k]   <= cnt_q[k] + CNT_W'(1);
        end else if (valid_q[k] && ready_v[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];
  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out2_valid = valid_q[2];
  assign out3_valid = valid_q[3];
  assign out0_cnt   = cnt_q[0];
  assign out1_cnt   = cnt_q[1];
  assign out2_cnt   = cnt_q[2];
  assign out3_cnt   = cnt_q[3];

endmodule

// File: tb/tb_demux1to4_reg.sv
// tb/tb_demux1to4_reg.sv - directed self-checking bench for demux1to4_reg
module tb_demux1to4_reg;
  localparam int NB = 512;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] od [4];
  logic          ov [4];
  logic          ordy [4];
  logic [CW-1:0] oc [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux1to4_reg #(.NUM_BITS(NB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(od[0]), .out0_valid(ov[0]), .out0_ready(ordy[0]), .out0_cnt(oc[0]),
    .out1_data(od[1]), .out1_valid(ov[1]), .out1_ready(ordy[1]), .out1_cnt(oc[1]),
    .out2_data(od[2]), .out2_valid(ov[2]), .out2_ready(ordy[2]), .out2_cnt(oc[2]),
    .out3_data(od[3]), .out3_valid(ov[3]), .out3_ready(ordy[3]), .out3_cnt(oc[3])
  );

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r0, input logic r1, input logic r2, input logic r3);
    ordy[0] = r0; ordy[1] = r1; ordy[2] = r2; ordy[3] = r3;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = NB'(5);
    set_ready(0, 0, 0, 0);

    // Reset held two cycles with in_valid asserted
    step(); step();
    chk("rst_in_ready", NB'(in_ready), NB'(0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), NB'(ov[k]), NB'(0));
      chk($sformatf("rst_data%0d", k), od[k], NB'(0));
      chk($sformatf("rst_cnt%0d", k), NB'(oc[k]), NB'(0));
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Steering: word k into lane k, later lanes still empty
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = NB'(k);
      #1;
      chk($sformatf("steer_in_ready%0d", k), NB'(in_ready), NB'(1));
      step();
      chk($sformatf("steer_data%0d", k), od[k], NB'(k));
      chk($sformatf("steer_valid%0d", k), NB'(ov[k]), NB'(1));
      chk($sformatf("steer_cnt%0d", k), NB'(oc[k]), NB'(1));
      for (int j = k + 1; j < 4; j++)
        chk($sformatf("steer_other%0d_%0d", k, j), NB'(ov[j]), NB'(0));
    end
    in_valid = 1'b0;

    // Back-pressure on full lane 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = NB'(99);
    #1;
    chk("bp_in_ready2", NB'(in_ready), NB'(0));
    step();
    chk("bp_data2", od[2], NB'(2));
    chk("bp_valid2", NB'(ov[2]), NB'(1));
    chk("bp_cnt2", NB'(oc[2]), NB'(1));
    in_valid = 1'b0; ordy[1] = 1'b1;
    step();
    chk("drain_valid1", NB'(ov[1]), NB'(0));
    chk("drain_data1_held", od[1], NB'(1));
    ordy[1] = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = NB'(77);
    #1;
    chk("bp_in_ready1", NB'(in_ready), NB'(1));
    step();
    in_valid = 1'b0;
    chk("bp_data1", od[1], NB'(77));
    chk("bp_cnt1", NB'(oc[1]), NB'(2));
    chk("bp_data2_stable", od[2], NB'(2));

    // Streaming 1..8 into lane 3 with consumer always ready (lane 3 starts full, cnt 1)
    ordy[3] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = 2'd3; in_data = NB'(i);
      #1;
      chk($sformatf("stream_in_ready%0d", i), NB'(in_ready), NB'(1));
      step();
      chk($sformatf("stream_data%0d", i), od[3], NB'(i));
      chk($sformatf("stream_valid%0d", i), NB'(ov[3]), NB'(1));
    end
    in_valid = 1'b0;
    chk("stream_cnt3", NB'(oc[3]), NB'(9));
    step();
    chk("stream_drained", NB'(ov[3]), NB'(0));
    chk("stream_data_hold", od[3], NB'(8));
    ordy[3] = 1'b0;

    // Wrap: lane 0 cnt=1, 17 more accepts -> 18 mod 16 = 2
    ordy[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = NB'(100 + i);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_cnt0", NB'(oc[0]), NB'(2));
    chk("wrap_data0", od[0], NB'(116));
    chk("wrap_lane1_cnt", NB'(oc[1]), NB'(2));

    // Mid-operation reset: drain, refill all lanes, then pulse reset
    set_ready(1, 1, 1, 1);
    step();
    set_ready(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = NB'(200 + k);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("full_valid%0d", k), NB'(ov[k]), NB'(1));
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = NB'(55);
    #1;
    chk("midrst_in_ready", NB'(in_ready), NB'(0));
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_valid%0d", k), NB'(ov[k]), NB'(0));
      chk($sformatf("midrst_cnt%0d", k), NB'(oc[k]), NB'(0));
    end
    in_valid = 1'b1; in_sel = 2'd1; in_data = NB'(321);
    step();
    in_valid = 1'b0;
    chk("post_rst_cnt1", NB'(oc[1]), NB'(1));
    chk("post_rst_data1", od[1], NB'(321));
    chk("post_rst_cnt0", NB'(oc[0]), NB'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
